mor1kx_bus_if_wb32_arb: RTL and testbench
=========================================

# mor1kx_bus_if_wb32_arb

Parametrised N-port Wishbone B3 master bridge. It merges several mor1kx CPU-side bus ports (ibus, dbus, auxiliary masters) onto one 32-bit Wishbone master, replacing the per-port single bridges. Arbitration is round-robin or fixed-priority, with wrapping read bursts, bounded retry handling and error termination. It sits between the CPU pipeline's bus ports and the SoC interconnect.

## Interface
- NUM_PORTS, 2: number of CPU-side ports (1..8).
- BURST_LENGTH, 8: read burst beats; legal values are 1, 4 and 8 (1 disables bursts).
- ARB_MODE, "ROUND_ROBIN": "ROUND_ROBIN" or "FIXED" (lowest index wins).
- RETRY_LIMIT, 4: consecutive rty per beat before error; 0 means unlimited.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- cpu_req_i  in  NUM_PORTS  per-port request; held until last ack/err.
- cpu_adr_i  in  NUM_PORTS*32  per-port byte address; port p uses slice [32p+31:32p].
- cpu_dat_i  in  NUM_PORTS*32  per-port write data.
- cpu_bsel_i  in  NUM_PORTS*4  per-port byte select.
- cpu_we_i  in  NUM_PORTS  write enable.
- cpu_burst_i  in  NUM_PORTS  burst request; honoured for reads only.
- cpu_ack_o  out  NUM_PORTS  per-port beat acknowledge.
- cpu_err_o  out  NUM_PORTS  per-port error termination.
- cpu_dat_o  out  32  read data, shared by all ports.
- grant_o  out  NUM_PORTS  one-hot current owner; zero when idle.
- wbm_adr_o / wbm_dat_o  out  32  registered address and write data.
- wbm_sel_o  out  4  registered byte select.
- wbm_cyc_o, wbm_stb_o, wbm_we_o  out  1  registered cycle, strobe and write enable.
- wbm_cti_o  out  3  registered cycle type identifier.
- wbm_bte_o  out  2  registered burst type extension.
- wbm_ack_i, wbm_err_i, wbm_rty_i  in  1  slave responses.
- wbm_dat_i  in  32  slave read data.

## Operation
- FSM states: IDLE, ACCESS, RETRY.
- IDLE:
  - If any cpu_req_i is set, select winner g and latch it into grant_o.
  - ROUND_ROBIN: search begins at last_grant+1 modulo NUM_PORTS; last_grant resets to NUM_PORTS-1, so port 0 wins first.
  - FIXED: lowest index wins.
  - Register adr, dat, sel and we of port g; set cyc=stb=1; go to ACCESS.
- Burst mode applies when cpu_burst_i[g]=1, cpu_we_i[g]=0 and BURST_LENGTH>1.
  - cti=010; bte=01 for 4 beats, 10 for 8 beats.
  - Last beat has cti=111.
  - Non-burst access: cti=111, bte=00.
- Burst address advance, on each ack:
  - adr[log2(BURST_LENGTH)+1:2] increments modulo BURST_LENGTH.
  - Upper bits are held, giving a wrapping burst.
  - Beat counter counts BURST_LENGTH-1 down to 0.
- ACCESS responses:
  - wbm_ack_i: cpu_ack_o[g]=1 and cpu_dat_o=wbm_dat_i in the same cycle (combinational, qualified by cyc and grant). On the last beat, drop cyc/stb/grant next cycle and go to IDLE.
  - wbm_err_i: cpu_err_o[g]=1 in the same cycle; transaction aborted; remaining beats abandoned; go to IDLE.
  - wbm_rty_i: retry counter increments. If the count reaches RETRY_LIMIT (nonzero), assert cpu_err_o[g] and go to IDLE. Otherwise drop cyc/stb for one cycle (RETRY) and reissue the same beat address. The retry counter clears on ack.
- Simultaneous ack/err/rty: err takes priority, then ack, then rty.
- Granted port drops cpu_req_i mid-transaction:
  - Current beat stays on the bus until ack/err/rty.
  - cpu_ack_o/cpu_err_o to that port are suppressed.
  - FSM then returns to IDLE.
- Requests from non-granted ports wait; their inputs are ignored until granted.
- cpu_dat_o = wbm_dat_i at all times; it is valid only with ack.

## Timing
- Reset (asynchronous):
  - wbm_cyc/stb/we = 0; wbm_adr/dat = 0; sel = 0; cti = 0; bte = 0.
  - grant_o = 0; state = IDLE.
  - Counters and last_grant are reset.
  - Reset mid-burst drops cyc immediately, without waiting for a clock edge.
- cpu_ack_o/cpu_err_o are 0 whenever cyc=0.
- Request sampled in IDLE at cycle N gives wbm_cyc_o=1 at N+1.
- Minimum single access: ack at N+1 gives cpu_ack_o at N+1 and cyc=0 at N+2.
- Every transaction is followed by at least one IDLE cycle with cyc=0. The next grant asserts cyc at N+3 at the earliest.
- A burst with zero-wait ack gives one beat per cycle; cti/adr update on the clock edge after each ack.
- Each RETRY adds exactly one cycle with cyc=0 before reissue.

## Test plan
- Single read, port 0, adr 0x100. Slave acks at first cycle with 0xDEADBEEF → cyc one cycle after req, cti=111, cpu_ack_o=01, cpu_dat_o=0xDEADBEEF, cyc=0 the next cycle.
- Burst read, port 1, adr 0x1018, BURST_LENGTH=8 → wbm_adr sequence 0x1018, 0x101C, 0x1000, 0x1004, 0x1008, 0x100C, 0x1010, 0x1014; bte=10; cti=010 for 7 beats then 111; eight cpu_ack_o[1] pulses.
- Ports 0 and 1 request continuously in ROUND_ROBIN → grants 0,1,0,1 with one idle cycle between. In FIXED → port 0 every time.
- RETRY_LIMIT=2, single write 0x2000: first rty → cyc=0 for one cycle then reissue of 0x2000; second rty → cpu_err_o pulse and IDLE, with no cpu_ack_o.
- 4-beat burst with err on beat 3 → two acks, then cpu_err_o on beat 3, cyc=0 next cycle, no further beats.
- rst asserted mid-burst at beat 5 → cyc, stb and grant go to 0 asynchronously. After release, a new request from port 0 is granted first.

Source files
------------

// File: rtl/mor1kx_bus_if_wb32_arb.sv
// N-port mor1kx CPU bus to single 32-bit Wishbone B3 master bridge.
// Supports round-robin or fixed arbitration, wrapping read bursts, bounded retry and error termination.
module mor1kx_bus_if_wb32_arb #(
    parameter int    NUM_PORTS    = 2,
    parameter int    BURST_LENGTH = 8,
    parameter string ARB_MODE     = "ROUND_ROBIN",
    parameter int    RETRY_LIMIT  = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_PORTS-1:0]      cpu_req_i,
    input  logic [NUM_PORTS*32-1:0]   cpu_adr_i,
    input  logic [NUM_PORTS*32-1:0]   cpu_dat_i,
    input  logic [NUM_PORTS*4-1:0]    cpu_bsel_i,
    input  logic [NUM_PORTS-1:0]      cpu_we_i,
    input  logic [NUM_PORTS-1:0]      cpu_burst_i,
    output logic [NUM_PORTS-1:0]      cpu_ack_o,
    output logic [NUM_PORTS-1:0]      cpu_err_o,
    output logic [31:0]               cpu_dat_o,
    output logic [NUM_PORTS-1:0]      grant_o,
    output logic [31:0]               wbm_adr_o,
    output logic [31:0]               wbm_dat_o,
    output logic [3:0]                wbm_sel_o,
    output logic                      wbm_cyc_o,
    output logic                      wbm_stb_o,
    output logic                      wbm_we_o,
    output logic [2:0]                wbm_cti_o,
    output logic [1:0]                wbm_bte_o,
    input  logic                      wbm_ack_i,
    input  logic                      wbm_err_i,
    input  logic                      wbm_rty_i,
    input  logic [31:0]               wbm_dat_i
);

    localparam int          IDX_W      = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam bit          FIXED_ARB  = (ARB_MODE == "FIXED");
    localparam logic [31:0] WRAP_MASK  = 32'((BURST_LENGTH - 1) * 4);
    localparam logic [3:0]  BEAT_INIT  = 4'(BURST_LENGTH - 1);
    localparam logic [1:0]  BTE_BURST  = (BURST_LENGTH == 4) ? 2'b01 : 2'b10;
    localparam logic [15:0] RETRY_MAX  = 16'(RETRY_LIMIT);

    typedef enum logic [1:0] {IDLE, ACCESS, RETRY} state_t;

    state_t           state;
    state_t           next_state;
    logic [IDX_W-1:0] gidx;
    logic [IDX_W-1:0] last_grant;
    logic [IDX_W-1:0] win;
    logic             win_valid;
    logic             win_burst;
    logic             burst;
    logic [3:0]       beat_cnt;
    logic [15:0]      retry_cnt;
    logic             req_held;
    logic             resp_err;
    logic             resp_ack;
    logic             resp_rty;
    logic             retry_fail;
    logic             last_beat;

    logic [31:0] port_adr [NUM_PORTS];
    logic [31:0] port_dat [NUM_PORTS];
    logic [3:0]  port_sel [NUM_PORTS];

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        assign port_adr[p] = cpu_adr_i[32*p +: 32];
        assign port_dat[p] = cpu_dat_i[32*p +: 32];
        assign port_sel[p] = cpu_bsel_i[4*p +: 4];
    end

    // Search order slot i (1..NUM_PORTS); round-robin starts one past the last owner.
    function automatic logic [IDX_W-1:0] slot(input int i, input logic [IDX_W-1:0] lg);
        if (FIXED_ARB)
            return IDX_W'(i - 1);
        return IDX_W'((int'(lg) + i) % NUM_PORTS);
    endfunction

    always_comb begin
        win       = '0;
        win_valid = 1'b0;
        for (int i = NUM_PORTS; i >= 1; i--) begin
            if (cpu_req_i[slot(i, last_grant)]) begin
                win       = slot(i, last_grant);
                win_valid = 1'b1;
            end
        end
    end

    assign win_burst  = cpu_burst_i[win] & ~cpu_we_i[win] & (BURST_LENGTH > 1);
    assign req_held   = cpu_req_i[gidx];
    assign resp_err   = wbm_err_i;
    assign resp_ack   = wbm_ack_i & ~wbm_err_i;
    assign resp_rty   = wbm_rty_i & ~wbm_ack_i & ~wbm_err_i;
    assign retry_fail = resp_rty && (RETRY_LIMIT != 0) && ((retry_cnt + 16'd1) >= RETRY_MAX);
    assign last_beat  = !burst || (beat_cnt == 4'd0);
    assign cpu_dat_o  = wbm_dat_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (win_valid)
                    next_state = ACCESS;
            end
            ACCESS: begin
                if (resp_err || retry_fail ||
                    (resp_ack && (last_beat || !req_held)) ||
                    (resp_rty && !req_held))
                    next_state = IDLE;
                else if (resp_rty)
                    next_state = RETRY;
            end
            RETRY: begin
                next_state = req_held ? ACCESS : IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Responses reach the owner only while it still wants them.
    always_comb begin
        cpu_ack_o = '0;
        cpu_err_o = '0;
        if (state == ACCESS && wbm_cyc_o && req_held) begin
            cpu_ack_o[gidx] = resp_ack;
            cpu_err_o[gidx] = resp_err | retry_fail;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gidx       <= '0;
            last_grant <= IDX_W'(NUM_PORTS - 1);
            grant_o    <= '0;
            wbm_adr_o  <= '0;
            wbm_dat_o  <= '0;
            wbm_sel_o  <= '0;
            wbm_we_o   <= 1'b0;
            wbm_cyc_o  <= 1'b0;
            wbm_stb_o  <= 1'b0;
            wbm_cti_o  <= '0;
            wbm_bte_o  <= '0;
            burst      <= 1'b0;
            beat_cnt   <= '0;
            retry_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_valid) begin
                        gidx       <= win;
                        last_grant <= win;
                        grant_o    <= NUM_PORTS'(1) << win;
                        wbm_adr_o  <= port_adr[win];
                        wbm_dat_o  <= port_dat[win];
                        wbm_sel_o  <= port_sel[win];
                        wbm_we_o   <= cpu_we_i[win];
                        wbm_cyc_o  <= 1'b1;
                        wbm_stb_o  <= 1'b1;
                        burst      <= win_burst;
                        wbm_cti_o  <= win_burst ? 3'b010 : 3'b111;
                        wbm_bte_o  <= win_burst ? BTE_BURST : 2'b00;
                        beat_cnt   <= BEAT_INIT;
                        retry_cnt  <= '0;
                    end
                end
                ACCESS: begin
                    if (next_state == IDLE) begin
                        wbm_cyc_o <= 1'b0;
                        wbm_stb_o <= 1'b0;
                        grant_o   <= '0;
                    end else if (next_state == RETRY) begin
                        wbm_cyc_o <= 1'b0;
                        wbm_stb_o <= 1'b0;
                        retry_cnt <= retry_cnt + 16'd1;
                    end else if (resp_ack) begin
                        // Wrap within the aligned burst block; upper address bits stay put.
                        wbm_adr_o <= (wbm_adr_o & ~WRAP_MASK) | ((wbm_adr_o + 32'd4) & WRAP_MASK);
                        beat_cnt  <= beat_cnt - 4'd1;
                        retry_cnt <= '0;
                        if (beat_cnt == 4'd1)
                            wbm_cti_o <= 3'b111;
                    end
                end
                RETRY: begin
                    if (next_state == ACCESS) begin
                        wbm_cyc_o <= 1'b1;
                        wbm_stb_o <= 1'b1;
                    end else begin
                        grant_o <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mor1kx_bus_if_wb32_arb.sv
// Directed bench: instance A is round-robin/8-beat/retry-limit 2, instance B is fixed/4-beat/unlimited retry.
module tb_mor1kx_bus_if_wb32_arb;

    logic        clk;
    logic        rst;
    logic [1:0]  cpu_req;
    logic [1:0]  cpu_we;
    logic [1:0]  cpu_burst;
    logic [63:0] cpu_adr;
    logic [63:0] cpu_dat;
    logic [7:0]  cpu_bsel;
    logic        wbm_ack;
    logic        wbm_err;
    logic        wbm_rty;
    logic [31:0] wbm_rdat;

    logic [1:0]  a_ack, a_err, a_grant, a_bte;
    logic [31:0] a_rdat, a_adr, a_wdat;
    logic [3:0]  a_sel;
    logic        a_cyc, a_stb, a_we;
    logic [2:0]  a_cti;

    logic [1:0]  b_ack, b_err, b_grant, b_bte;
    logic [31:0] b_rdat, b_adr, b_wdat;
    logic [3:0]  b_sel;
    logic        b_cyc, b_stb, b_we;
    logic [2:0]  b_cti;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] burst_adr [8];
    logic [31:0] exp_adr;
    logic [2:0]  exp_cti;
    logic [1:0]  exp_grant;

    mor1kx_bus_if_wb32_arb #(
        .NUM_PORTS(2), .BURST_LENGTH(8), .ARB_MODE("ROUND_ROBIN"), .RETRY_LIMIT(2)
    ) dut_a (
        .clk(clk), .rst(rst),
        .cpu_req_i(cpu_req), .cpu_adr_i(cpu_adr), .cpu_dat_i(cpu_dat), .cpu_bsel_i(cpu_bsel),
        .cpu_we_i(cpu_we), .cpu_burst_i(cpu_burst),
        .cpu_ack_o(a_ack), .cpu_err_o(a_err), .cpu_dat_o(a_rdat), .grant_o(a_grant),
        .wbm_adr_o(a_adr), .wbm_dat_o(a_wdat), .wbm_sel_o(a_sel),
        .wbm_cyc_o(a_cyc), .wbm_stb_o(a_stb), .wbm_we_o(a_we),
        .wbm_cti_o(a_cti), .wbm_bte_o(a_bte),
        .wbm_ack_i(wbm_ack), .wbm_err_i(wbm_err), .wbm_rty_i(wbm_rty), .wbm_dat_i(wbm_rdat)
    );

    mor1kx_bus_if_wb32_arb #(
        .NUM_PORTS(2), .BURST_LENGTH(4), .ARB_MODE("FIXED"), .RETRY_LIMIT(0)
    ) dut_b (
        .clk(clk), .rst(rst),
        .cpu_req_i(cpu_req), .cpu_adr_i(cpu_adr), .cpu_dat_i(cpu_dat), .cpu_bsel_i(cpu_bsel),
        .cpu_we_i(cpu_we), .cpu_burst_i(cpu_burst),
        .cpu_ack_o(b_ack), .cpu_err_o(b_err), .cpu_dat_o(b_rdat), .grant_o(b_grant),
        .wbm_adr_o(b_adr), .wbm_dat_o(b_wdat), .wbm_sel_o(b_sel),
        .wbm_cyc_o(b_cyc), .wbm_stb_o(b_stb), .wbm_we_o(b_we),
        .wbm_cti_o(b_cti), .wbm_bte_o(b_bte),
        .wbm_ack_i(wbm_ack), .wbm_err_i(wbm_err), .wbm_rty_i(wbm_rty), .wbm_dat_i(wbm_rdat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task step();
        @(posedge clk);
        #1;
    endtask

    task clear_inputs();
        cpu_req   = '0;
        cpu_we    = '0;
        cpu_burst = '0;
        cpu_adr   = '0;
        cpu_dat   = '0;
        cpu_bsel  = 8'hFF;
        wbm_ack   = 1'b0;
        wbm_err   = 1'b0;
        wbm_rty   = 1'b0;
        wbm_rdat  = '0;
    endtask

    task do_reset();
        rst = 1'b1;
        clear_inputs();
        step();
        step();
        rst = 1'b0;
    endtask

    task test_reset();
        rst = 1'b1;
        clear_inputs();
        step();
        checks++;
        if ({a_cyc, a_stb, a_we} !== 3'b000) begin errors++; $display("[TB] FAIL reset_ctrl: got %b want 000", {a_cyc, a_stb, a_we}); end
        checks++;
        if (a_grant !== 2'b00) begin errors++; $display("[TB] FAIL reset_grant: got %b want 00", a_grant); end
        checks++;
        if ({a_adr, a_wdat} !== 64'd0) begin errors++; $display("[TB] FAIL reset_adr_dat: got %h want 0", {a_adr, a_wdat}); end
        checks++;
        if ({a_sel, a_cti, a_bte} !== 9'd0) begin errors++; $display("[TB] FAIL reset_sel_cti_bte: got %h want 0", {a_sel, a_cti, a_bte}); end
        rst = 1'b0;
    endtask

    task test_single_read();
        do_reset();
        cpu_adr[31:0] = 32'h100;
        cpu_req       = 2'b01;
        #1;
        checks++;
        if (a_cyc !== 1'b0) begin errors++; $display("[TB] FAIL single_cyc_early: got %b want 0", a_cyc); end
        step();
        checks++;
        if ({a_cyc, a_stb} !== 2'b11) begin errors++; $display("[TB] FAIL single_cyc: got %b want 11", {a_cyc, a_stb}); end
        checks++;
        if (a_adr !== 32'h100) begin errors++; $display("[TB] FAIL single_adr: got %h want 00000100", a_adr); end
        checks++;
        if (a_cti !== 3'b111) begin errors++; $display("[TB] FAIL single_cti: got %b want 111", a_cti); end
        checks++;
        if (a_grant !== 2'b01) begin errors++; $display("[TB] FAIL single_grant: got %b want 01", a_grant); end
        wbm_ack  = 1'b1;
        wbm_rdat = 32'hDEADBEEF;
        #1;
        checks++;
        if (a_ack !== 2'b01) begin errors++; $display("[TB] FAIL single_ack: got %b want 01", a_ack); end
        checks++;
        if (a_rdat !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL single_rdata: got %h want deadbeef", a_rdat); end
        step();
        wbm_ack = 1'b0;
        cpu_req = 2'b00;
        checks++;
        if ({a_cyc, a_grant} !== 3'b000) begin errors++; $display("[TB] FAIL single_end: got %b want 000", {a_cyc, a_grant}); end
    endtask

    task test_burst();
        burst_adr = '{32'h1018, 32'h101C, 32'h1000, 32'h1004, 32'h1008, 32'h100C, 32'h1010, 32'h1014};
        do_reset();
        cpu_adr[63:32] = 32'h1018;
        cpu_burst      = 2'b10;
        cpu_req        = 2'b10;
        step();
        checks++;
        if ({a_grant, a_bte} !== 4'b1010) begin errors++; $display("[TB] FAIL burst_grant_bte: got %b want 1010", {a_grant, a_bte}); end
        for (int i = 0; i < 8; i++) begin
            exp_adr = burst_adr[i];
            exp_cti = (i == 7) ? 3'b111 : 3'b010;
            checks++;
            if (a_adr !== exp_adr) begin errors++; $display("[TB] FAIL burst_adr beat %0d: got %h want %h", i, a_adr, exp_adr); end
            checks++;
            if (a_cti !== exp_cti) begin errors++; $display("[TB] FAIL burst_cti beat %0d: got %b want %b", i, a_cti, exp_cti); end
            wbm_ack = 1'b1;
            #1;
            checks++;
            if (a_ack !== 2'b10) begin errors++; $display("[TB] FAIL burst_ack beat %0d: got %b want 10", i, a_ack); end
            step();
        end
        wbm_ack   = 1'b0;
        cpu_req   = 2'b00;
        cpu_burst = 2'b00;
        checks++;
        if (a_cyc !== 1'b0) begin errors++; $display("[TB] FAIL burst_end_cyc: got %b want 0", a_cyc); end
    endtask

    task test_arbitration();
        do_reset();
        cpu_adr = {32'h20, 32'h10};
        cpu_req = 2'b11;
        wbm_ack = 1'b1;
        for (int t = 0; t < 4; t++) begin
            step();
            exp_grant = (t % 2 == 1) ? 2'b10 : 2'b01;
            exp_adr   = (t % 2 == 1) ? 32'h20 : 32'h10;
            checks++;
            if (a_grant !== exp_grant) begin errors++; $display("[TB] FAIL rr_grant %0d: got %b want %b", t, a_grant, exp_grant); end
            checks++;
            if (a_adr !== exp_adr) begin errors++; $display("[TB] FAIL rr_adr %0d: got %h want %h", t, a_adr, exp_adr); end
            checks++;
            if (b_grant !== 2'b01) begin errors++; $display("[TB] FAIL fixed_grant %0d: got %b want 01", t, b_grant); end
            step();
            checks++;
            if ({a_cyc, b_cyc} !== 2'b00) begin errors++; $display("[TB] FAIL arb_idle_gap %0d: got %b want 00", t, {a_cyc, b_cyc}); end
        end
        wbm_ack = 1'b0;
        cpu_req = 2'b00;
    endtask

    task test_retry();
        do_reset();
        cpu_adr[31:0] = 32'h2000;
        cpu_dat[31:0] = 32'h12345678;
        cpu_bsel      = 8'h0F;
        cpu_we        = 2'b01;
        cpu_req       = 2'b01;
        step();
        checks++;
        if ({a_we, a_sel, a_adr, a_wdat} !== {1'b1, 4'hF, 32'h2000, 32'h12345678}) begin
            errors++; $display("[TB] FAIL retry_issue: got we=%b sel=%h adr=%h dat=%h want 1 f 00002000 12345678", a_we, a_sel, a_adr, a_wdat);
        end
        wbm_rty = 1'b1;
        #1;
        checks++;
        if ({a_ack, a_err} !== 4'b0000) begin errors++; $display("[TB] FAIL retry_first_resp: got %b want 0000", {a_ack, a_err}); end
        step();
        wbm_rty = 1'b0;
        checks++;
        if ({a_cyc, a_grant} !== 3'b001) begin errors++; $display("[TB] FAIL retry_gap: got %b want 001", {a_cyc, a_grant}); end
        step();
        checks++;
        if ({a_cyc, a_adr} !== {1'b1, 32'h2000}) begin errors++; $display("[TB] FAIL retry_reissue: got cyc=%b adr=%h want 1 00002000", a_cyc, a_adr); end
        wbm_rty = 1'b1;
        #1;
        checks++;
        if ({a_err, a_ack} !== 4'b0100) begin errors++; $display("[TB] FAIL retry_limit_err: got %b want 0100", {a_err, a_ack}); end
        checks++;
        if (b_err !== 2'b00) begin errors++; $display("[TB] FAIL retry_unlimited: got %b want 00", b_err); end
        step();
        wbm_rty = 1'b0;
        cpu_req = 2'b00;
        cpu_we  = 2'b00;
        checks++;
        if ({a_cyc, a_grant} !== 3'b000) begin errors++; $display("[TB] FAIL retry_end: got %b want 000", {a_cyc, a_grant}); end
    endtask

    task test_burst_err();
        do_reset();
        cpu_adr[31:0] = 32'h40;
        cpu_burst     = 2'b01;
        cpu_req       = 2'b01;
        step();
        checks++;
        if ({b_bte, b_cti} !== 5'b01010) begin errors++; $display("[TB] FAIL berr_bte_cti: got %b want 01010", {b_bte, b_cti}); end
        for (int i = 0; i < 2; i++) begin
            exp_adr = 32'h40 + 32'(4 * i);
            checks++;
            if (b_adr !== exp_adr) begin errors++; $display("[TB] FAIL berr_adr beat %0d: got %h want %h", i, b_adr, exp_adr); end
            wbm_ack = 1'b1;
            #1;
            checks++;
            if (b_ack !== 2'b01) begin errors++; $display("[TB] FAIL berr_ack beat %0d: got %b want 01", i, b_ack); end
            step();
        end
        checks++;
        if (b_adr !== 32'h48) begin errors++; $display("[TB] FAIL berr_adr3: got %h want 00000048", b_adr); end
        wbm_ack = 1'b1;
        wbm_err = 1'b1;
        #1;
        checks++;
        if ({b_err, b_ack} !== 4'b0100) begin errors++; $display("[TB] FAIL berr_err_priority: got %b want 0100", {b_err, b_ack}); end
        step();
        wbm_ack   = 1'b0;
        wbm_err   = 1'b0;
        cpu_req   = 2'b00;
        cpu_burst = 2'b00;
        checks++;
        if ({b_cyc, b_grant} !== 3'b000) begin errors++; $display("[TB] FAIL berr_end: got %b want 000", {b_cyc, b_grant}); end
    endtask

    task test_req_drop();
        do_reset();
        cpu_adr[31:0] = 32'h500;
        cpu_req       = 2'b01;
        step();
        cpu_req = 2'b00;
        wbm_ack = 1'b1;
        #1;
        checks++;
        if (a_ack !== 2'b00) begin errors++; $display("[TB] FAIL drop_ack_suppressed: got %b want 00", a_ack); end
        step();
        wbm_ack = 1'b0;
        checks++;
        if (a_cyc !== 1'b0) begin errors++; $display("[TB] FAIL drop_end_cyc: got %b want 0", a_cyc); end
    endtask

    task test_reset_mid_burst();
        do_reset();
        cpu_adr[63:32] = 32'h1018;
        cpu_burst      = 2'b10;
        cpu_req        = 2'b10;
        step();
        wbm_ack = 1'b1;
        repeat (4) step();
        wbm_ack = 1'b0;
        checks++;
        if ({a_cyc, a_adr} !== {1'b1, 32'h1008}) begin errors++; $display("[TB] FAIL midrst_beat5: got cyc=%b adr=%h want 1 00001008", a_cyc, a_adr); end
        rst = 1'b1;
        #1;
        checks++;
        if ({a_cyc, a_stb, a_grant} !== 4'b0000) begin errors++; $display("[TB] FAIL midrst_async: got %b want 0000", {a_cyc, a_stb, a_grant}); end
        rst           = 1'b0;
        cpu_burst     = 2'b00;
        cpu_adr[31:0] = 32'h300;
        cpu_req       = 2'b11;
        step();
        checks++;
        if ({a_grant, a_adr} !== {2'b01, 32'h300}) begin errors++; $display("[TB] FAIL midrst_regrant: got grant=%b adr=%h want 01 00000300", a_grant, a_adr); end
        cpu_req = 2'b00;
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_single_read();
        test_burst();
        test_arbitration();
        test_retry();
        test_burst_err();
        test_req_drop();
        test_reset_mid_burst();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
